// File: rtl/prog_seq_counter.sv
// prog_seq_counter: programmable sequence counter.
// Steps through a writable table of DEPTH codes. It can step forward or in
// reverse, and it can wrap or run a single pass. It has start, stop and
// enable control, and it pulses done when the sequence ends.
//
// Optional build macro: PROG_SEQ_COUNTER_PARITY_EN adds a per-entry parity
// store plus the out_par and par_err outputs.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       advance enable (hold when low in RUN)
//   start    (re)start pulse
//   stop     return-to-IDLE pulse (index held)
//   dir      0 = forward, 1 = reverse
//   mode     0 = wrap, 1 = one-shot
//   len      active entry count (0 -> 1, >DEPTH -> DEPTH)
//   wr_en    table write strobe
//   wr_addr  table write index
//   wr_data  table write data
//   out      table[idx] (combinational read of registers)
//   idx      current table index
//   busy     high in RUN
//   done     one-cycle end-of-sequence pulse
//   out_par  even parity of out          (parity build only)
//   par_err  stored parity mismatch      (parity build only)
module prog_seq_counter #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             mode,
    input  logic [IDX_W:0]   len,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done
`ifdef PROG_SEQ_COUNTER_PARITY_EN
    ,
    output logic             out_par,
    output logic             par_err
`endif
);

    localparam int unsigned LEN_W      = IDX_W + 1;
    localparam bit          DEPTH_POW2 = (DEPTH == (32'd1 << IDX_W));

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               busy_q;

    logic [WIDTH-1:0]   tbl [DEPTH];
    logic               wr_ok;

    logic [LEN_W-1:0]   eff_len;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   term_idx;
    logic [IDX_W-1:0]   step_idx;
    logic               out_of_range;

    // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
    generate
        if (DEPTH_POW2) begin : g_addr_full
            assign wr_ok = 1'b1;
        end else begin : g_addr_part
            assign wr_ok = (32'(wr_addr) < DEPTH);
        end
    endgenerate

    // Effective length plus first/terminal index, taken from the live len and dir.
    always_comb begin
        if (len == '0) begin
            eff_len = LEN_W'(1);
        end else if (len > LEN_W'(DEPTH)) begin
            eff_len = LEN_W'(DEPTH);
        end else begin
            eff_len = len;
        end
    end

    assign first_idx    = dir ? IDX_W'(eff_len - LEN_W'(1)) : '0;
    assign term_idx     = dir ? '0 : IDX_W'(eff_len - LEN_W'(1));
    assign step_idx     = dir ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    assign out_of_range = ({1'b0, idx_q} >= eff_len);

    // Next state, next index and done pulse. Inside RUN, stop wins over start, and start wins over en.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    idx_d   = first_idx;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (start) begin
                    idx_d = first_idx;
                end else if (en) begin
                    if (out_of_range) begin
                        // len shrank below idx: resync to the first index without done
                        idx_d = first_idx;
                    end else if (idx_q == term_idx) begin
                        done_d = 1'b1;
                        if (mode) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = first_idx;
                        end
                    end else begin
                        idx_d = step_idx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_RUN);
        end
    end

    // Code table. Reset loads the identity pattern and discards any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl[i] <= WIDTH'(i);
            end
        end else if (wr_en && wr_ok) begin
            tbl[wr_addr] <= wr_data;
        end
    end

    assign out  = tbl[idx_q];
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef PROG_SEQ_COUNTER_PARITY_EN
    logic tbl_par [DEPTH];

    // Parity store, written alongside the table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_par[i] <= ^(WIDTH'(i));
            end
        end else if (wr_en && wr_ok) begin
            tbl_par[wr_addr] <= ^wr_data;
        end
    end

    assign out_par = ^out;
    assign par_err = (tbl_par[idx_q] != ^tbl[idx_q]);
`endif

endmodule

// File: tb/tb_prog_seq_counter.sv
// Scoreboard bench for prog_seq_counter.
// The driver applies one set of inputs per cycle and pushes the expected
// post-edge outputs from a spec-level model. The monitor pops one entry
// after each rising edge and compares it with the DUT.
module tb_prog_seq_counter;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] len = 4'd8;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [2:0] wr_data = 3'd0;
    logic [2:0] out;
    logic [2:0] idx;
    logic       busy;
    logic       done;
`ifdef PROG_SEQ_COUNTER_PARITY_EN
    logic       out_par;
    logic       par_err;
`endif

    always #5 clk = ~clk;

    prog_seq_counter dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .start   (start),
        .stop    (stop),
        .dir     (dir),
        .mode    (mode),
        .len     (len),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .out     (out),
        .idx     (idx),
        .busy    (busy),
        .done    (done)
`ifdef PROG_SEQ_COUNTER_PARITY_EN
        ,
        .out_par (out_par),
        .par_err (par_err)
`endif
    );

    typedef struct packed {
        logic [2:0] out;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   drv_done = 1'b0;

    // Reference state: table contents, index, run flag, done flag.
    int   m_tbl [DEPTH];
    int   m_idx = 0;
    bit   m_run = 1'b0;
    bit   m_done = 1'b0;

    // Applies the spec rules to the current inputs for one clock edge, then queues the result.
    function automatic void model_step();
        int   l;
        int   f;
        int   t;
        bit   nd;
        exp_t e;
        nd = 1'b0;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % 8;
            m_idx = 0;
            m_run = 1'b0;
        end else begin
            l = (int'(len) == 0) ? 1 : ((int'(len) > DEPTH) ? DEPTH : int'(len));
            f = dir ? l - 1 : 0;
            t = dir ? 0 : l - 1;
            if (!m_run) begin
                if (start && !stop) begin
                    m_run = 1'b1;
                    m_idx = f;
                end
            end else if (stop) begin
                m_run = 1'b0;
            end else if (start) begin
                m_idx = f;
            end else if (en) begin
                if (m_idx >= l) begin
                    m_idx = f;
                end else if (m_idx == t) begin
                    nd = 1'b1;
                    if (mode) m_run = 1'b0;
                    else m_idx = f;
                end else begin
                    m_idx = dir ? m_idx - 1 : m_idx + 1;
                end
            end
            if (wr_en) m_tbl[int'(wr_addr)] = int'(wr_data);
        end
        m_done = nd;
        e.out  = 3'(m_tbl[m_idx]);
        e.idx  = 3'(m_idx);
        e.busy = m_run;
        e.done = m_done;
        exp_q.push_back(e);
    endfunction

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    // Monitor: one comparison per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (out !== e.out || idx !== e.idx || busy !== e.busy || done !== e.done) begin
                    n_err++;
                    $display("FAIL cyc%0d: got out=%0d idx=%0d busy=%0b done=%0b, need out=%0d idx=%0d busy=%0b done=%0b",
                             n_vec, out, idx, busy, done, e.out, e.idx, e.busy, e.done);
                end
`ifdef PROG_SEQ_COUNTER_PARITY_EN
                if (out_par !== ^e.out || par_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL parity cyc%0d: got out_par=%0b par_err=%0b, need out_par=%0b par_err=0",
                             n_vec, out_par, par_err, ^e.out);
                end
`endif
            end else if (!drv_done) begin
                n_err++;
                $display("FAIL scoreboard: edge with no expected entry queued");
            end
        end
    end

    // Driver.
    initial begin
        // reset
        rst = 1'b1; tick(2); rst = 1'b0;

        // legacy table 0,2,3,5,6 in wrap mode
        wr_en = 1'b1;
        wr_addr = 3'd0; wr_data = 3'd0; tick(1);
        wr_addr = 3'd1; wr_data = 3'd2; tick(1);
        wr_addr = 3'd2; wr_data = 3'd3; tick(1);
        wr_addr = 3'd3; wr_data = 3'd5; tick(1);
        wr_addr = 3'd4; wr_data = 3'd6; tick(1);
        wr_en = 1'b0;
        len = 4'd5; dir = 1'b0; mode = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        en = 1'b1; tick(12);

        // hold for three cycles, then resume
        en = 1'b0; tick(3); en = 1'b1; tick(2);

        // start and stop together in RUN
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(2);

        // restart from idx 3
        start = 1'b1; tick(1); start = 1'b0; tick(3);
        start = 1'b1; tick(1); start = 1'b0; tick(2);

        // reverse one-shot, then run again
        stop = 1'b1; tick(1); stop = 1'b0;
        dir = 1'b1; mode = 1'b1;
        start = 1'b1; tick(1); start = 1'b0; tick(7);
        start = 1'b1; tick(1); start = 1'b0; tick(6);

        // len = 0 in wrap mode
        dir = 1'b0; mode = 1'b0; len = 4'd0;
        start = 1'b1; tick(1); start = 1'b0; tick(4);

        // len = 12 clamps to DEPTH
        len = 4'd12;
        start = 1'b1; tick(1); start = 1'b0; tick(10);

        // len shrinks from 8 to 3 at idx 6
        len = 4'd8;
        start = 1'b1; tick(1); start = 1'b0; tick(6);
        len = 4'd3; tick(3);

        // reset at idx 4 while a write is pending
        len = 4'd8;
        start = 1'b1; tick(1); start = 1'b0; tick(4);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'd7; tick(1);
        rst = 1'b0; wr_en = 1'b0; tick(1);

        // write to the entry at the current idx
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        en = 1'b0; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 3'd7; tick(1);
        wr_en = 1'b0; tick(1);
        en = 1'b1;

        // parity codes 5 and 7 across a full wrap
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 3'd5; tick(1);
        wr_addr = 3'd6; wr_data = 3'd7; tick(1);
        wr_en = 1'b0; tick(10);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            en    = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 24) == 0) len = 4'($urandom_range(0, 15));
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 3'($urandom);
            wr_data = 3'($urandom);
            tick(1);
        end

        drv_done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected entries left unchecked", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
